alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Grants alternate on ties; each result is held until its owner consumes it.
package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } aluop_t;
endpackage

module alu_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_out,
    output logic        resp0_vf,
    output logic        resp0_zf,
    output logic        resp0_nf,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_out,
    output logic        resp1_vf,
    output logic        resp1_zf,
    output logic        resp1_nf,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_vf,
    input  logic        alu_zf,
    input  logic        alu_nf
);
    localparam int NREQ = 2;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;
    logic            w_prio_nxt;
    logic            r_owner;
    logic            w_owner_nxt;
    logic [31:0]     r_out [NREQ];
    logic [NREQ-1:0] r_vf;
    logic [NREQ-1:0] r_zf;
    logic [NREQ-1:0] r_nf;
    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_owner_rdy;

    // Gating with nRST keeps ready and the ALU bus quiet during reset
    assign w_idle      = (r_state == S_IDLE) && nRST;
    assign w_gnt0      = w_idle && req0_valid && (!req1_valid || !r_prio);
    assign w_gnt1      = w_idle && req1_valid && (!req0_valid || r_prio);
    assign w_owner_rdy = r_owner ? resp1_ready : resp0_ready;

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp0_valid = (r_state == S_RESP) && !r_owner;
    assign resp1_valid = (r_state == S_RESP) && r_owner;

    assign resp0_out = r_out[0];
    assign resp0_vf  = r_vf[0];
    assign resp0_zf  = r_zf[0];
    assign resp0_nf  = r_nf[0];
    assign resp1_out = r_out[1];
    assign resp1_vf  = r_vf[1];
    assign resp1_zf  = r_zf[1];
    assign resp1_nf  = r_nf[1];

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_owner_nxt = r_owner;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt0) begin
                    alu_a       = req0_a;
                    alu_b       = req0_b;
                    alu_op      = req0_op;
                    w_owner_nxt = 1'b0;
                    w_prio_nxt  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_gnt1) begin
                    alu_a       = req1_a;
                    alu_b       = req1_b;
                    alu_op      = req1_op;
                    w_owner_nxt = 1'b1;
                    w_prio_nxt  = 1'b0;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_owner_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Result registers keep their value after consumption
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREQ; i++) begin
                r_out[i] <= '0;
            end
            r_vf <= '0;
            r_zf <= '0;
            r_nf <= '0;
        end else if (w_gnt0 || w_gnt1) begin
            r_out[w_gnt1] <= alu_out;
            r_vf[w_gnt1]  <= alu_vf;
            r_zf[w_gnt1]  <= alu_zf;
            r_nf[w_gnt1]  <= alu_nf;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the shared bus.
// Directed scenarios push expected results; a negedge monitor pops and checks.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        logic [31:0] out;
        logic        vf;
        logic        zf;
        logic        nf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1, resp1_ready = 1;
    logic [31:0] resp0_out, resp1_out;
    logic        resp0_vf, resp0_zf, resp0_nf;
    logic        resp1_vf, resp1_zf, resp1_nf;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_vf, alu_zf, alu_nf;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_out(resp0_out), .resp0_vf(resp0_vf),
        .resp0_zf(resp0_zf), .resp0_nf(resp0_nf),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_out(resp1_out), .resp1_vf(resp1_vf),
        .resp1_zf(resp1_zf), .resp1_nf(resp1_nf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_vf(alu_vf),
        .alu_zf(alu_zf), .alu_nf(alu_nf)
    );

    // Behavioural shared ALU
    always_comb begin
        alu_out = '0;
        alu_vf  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_out = alu_a + alu_b;
                alu_vf  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_out = alu_a - alu_b;
                alu_vf  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
            ALU_SLL:  alu_out = alu_a << alu_b[4:0];
            ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
            default:  alu_out = '0;
        endcase
        alu_zf = (alu_out == 32'd0);
        alu_nf = alu_out[31];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] o, input logic v,
                                input logic z, input logic n);
        exp_t e;
        e.out = o;
        e.vf  = v;
        e.zf  = z;
        e.nf  = n;
        return e;
    endfunction

    // Monitor: pop on each new response, then check it stays stable
    initial begin
        logic prev0, prev1;
        exp_t cur0, cur1;
        prev0 = 0;
        prev1 = 0;
        cur0 = mk(0, 0, 0, 0);
        cur1 = mk(0, 0, 0, 0);
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                prev0 = 0;
                prev1 = 0;
            end else begin
                chk("one_resp_valid", {31'd0, resp0_valid & resp1_valid}, 0);
                if (!req0_ready && !req1_ready) begin
                    chk("alu_bus_idle", alu_a | alu_b | {28'd0, alu_op}, 0);
                end
                if (resp0_valid) begin
                    if (!prev0) begin
                        if (q0.size() == 0) begin
                            chk("resp0_unexpected", 1, 0);
                        end else begin
                            cur0 = q0.pop_front();
                        end
                    end
                    chk("resp0_out", resp0_out, cur0.out);
                    chk("resp0_flags", {29'd0, resp0_vf, resp0_zf, resp0_nf},
                        {29'd0, cur0.vf, cur0.zf, cur0.nf});
                end
                if (resp1_valid) begin
                    if (!prev1) begin
                        if (q1.size() == 0) begin
                            chk("resp1_unexpected", 1, 0);
                        end else begin
                            cur1 = q1.pop_front();
                        end
                    end
                    chk("resp1_out", resp1_out, cur1.out);
                    chk("resp1_flags", {29'd0, resp1_vf, resp1_zf, resp1_nf},
                        {29'd0, cur1.vf, cur1.zf, cur1.nf});
                end
                prev0 = resp0_valid;
                prev1 = resp1_valid;
            end
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        req0_valid = 1;
        req0_a = 32'd9;
        req0_b = 32'd1;
        req0_op = ALU_ADD;
        repeat (2) @(negedge CLK);
        chk("rst_req0_ready", {31'd0, req0_ready}, 0);
        chk("rst_alu_bus", alu_a | alu_b | {28'd0, alu_op}, 0);
        chk("rst_resp_valid", {30'd0, resp0_valid, resp1_valid}, 0);
        chk("rst_resp0_out", resp0_out, 0);
        chk("rst_resp1_out", resp1_out, 0);
        chk("rst_flags", {26'd0, resp0_vf, resp0_zf, resp0_nf,
                          resp1_vf, resp1_zf, resp1_nf}, 0);
        req0_valid = 0;
        @(negedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single ADD from req0
        tick();
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = ALU_ADD;
        q0.push_back(mk(32'd12, 0, 0, 0));
        @(negedge CLK);
        chk("add_rdy0", {31'd0, req0_ready}, 1);
        chk("add_rdy1", {31'd0, req1_ready}, 0);
        tick();
        req0_valid = 0;
        @(negedge CLK);
        chk("add_resp0_valid", {31'd0, resp0_valid}, 1);
        chk("add_resp1_valid", {31'd0, resp1_valid}, 0);
        tick();
        @(negedge CLK);
        chk("add_resp0_clear", {31'd0, resp0_valid}, 0);

        // Simultaneous requests after reset: req0 wins
        do_reset();
        tick();
        resp0_ready = 0; resp1_ready = 0;
        req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = ALU_SUB;
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = ALU_OR;
        q0.push_back(mk(32'd0, 0, 1, 0));
        q1.push_back(mk(32'd7, 0, 0, 0));
        @(negedge CLK);
        chk("tie_rdy0", {31'd0, req0_ready}, 1);
        chk("tie_rdy1", {31'd0, req1_ready}, 0);
        tick();
        req0_valid = 0;
        @(negedge CLK);
        chk("tie_resp0_valid", {31'd0, resp0_valid}, 1);
        chk("tie_rdy1_resp", {31'd0, req1_ready}, 0);
        tick();
        resp0_ready = 1;
        @(negedge CLK);
        chk("tie_resp0_hold", {31'd0, resp0_valid}, 1);
        tick();
        resp0_ready = 0;
        @(negedge CLK);
        chk("tie_rdy1_grant", {31'd0, req1_ready}, 1);
        chk("tie_resp0_gone", {31'd0, resp0_valid}, 0);
        tick();
        req1_valid = 0;
        resp1_ready = 1;
        @(negedge CLK);
        chk("tie_resp1_valid", {31'd0, resp1_valid}, 1);
        tick();
        @(negedge CLK);
        chk("tie_resp1_clear", {31'd0, resp1_valid}, 0);

        // Continuous contention: grants alternate every other cycle
        resp0_ready = 1; resp1_ready = 1;
        tick();
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = ALU_ADD;
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = ALU_AND;
        repeat (2) q0.push_back(mk(32'd2, 0, 0, 0));
        repeat (2) q1.push_back(mk(32'h30, 0, 0, 0));
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk($sformatf("alt_rdy0_c%0d", c), {31'd0, req0_ready},
                {31'd0, (c % 4) == 0});
            chk($sformatf("alt_rdy1_c%0d", c), {31'd0, req1_ready},
                {31'd0, (c % 4) == 2});
        end
        tick();
        req0_valid = 0; req1_valid = 0;

        // Overflowing ADD held by a stalled consumer
        resp1_ready = 0;
        tick();
        req1_valid = 1; req1_a = 32'h7FFF_FFFF; req1_b = 1; req1_op = ALU_ADD;
        q1.push_back(mk(32'h8000_0000, 1, 0, 1));
        @(negedge CLK);
        chk("ovf_rdy1", {31'd0, req1_ready}, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_a = 2; req0_b = 3; req0_op = ALU_ADD;
        q0.push_back(mk(32'd5, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("ovf_hold_valid", {31'd0, resp1_valid}, 1);
            chk("ovf_hold_rdy", {30'd0, req0_ready, req1_ready}, 0);
        end
        tick();
        resp1_ready = 1;
        @(negedge CLK);
        chk("ovf_still_valid", {31'd0, resp1_valid}, 1);
        tick();
        resp1_ready = 0;
        @(negedge CLK);
        chk("ovf_cleared", {31'd0, resp1_valid}, 0);
        chk("ovf_rdy0_next", {31'd0, req0_ready}, 1);
        chk("ovf_retained", resp1_out, 32'h8000_0000);
        chk("ovf_flags_kept", {29'd0, resp1_vf, resp1_zf, resp1_nf}, 32'd5);
        tick();
        req0_valid = 0;
        @(negedge CLK);
        chk("post_ovf_resp0", {31'd0, resp0_valid}, 1);
        tick();
        @(negedge CLK);
        chk("post_ovf_clear", {31'd0, resp0_valid}, 0);

        // Reset while a req0 result is pending
        resp0_ready = 0;
        tick();
        req0_valid = 1; req0_a = 10; req0_b = 4; req0_op = ALU_SUB;
        q0.push_back(mk(32'd6, 0, 0, 0));
        @(negedge CLK);
        chk("rr_rdy0", {31'd0, req0_ready}, 1);
        tick();
        req0_valid = 0;
        @(negedge CLK);
        chk("rr_resp0_valid", {31'd0, resp0_valid}, 1);
        #3;
        nRST = 1'b0;
        #1;
        chk("rr_async_drop", {31'd0, resp0_valid}, 0);
        chk("rr_out_cleared", resp0_out, 0);
        repeat (2) @(negedge CLK);
        chk("rr_no_resp", {30'd0, resp0_valid, resp1_valid}, 0);
        @(negedge CLK);
        #1;
        nRST = 1'b1;
        resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req0_a = 32'hFFFF_FC00; req0_b = 233; req0_op = ALU_SLT;
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = ALU_SUB;
        q0.push_back(mk(32'd1, 0, 0, 0));
        q1.push_back(mk(32'hFFFF_FFFF, 0, 0, 1));
        #1;
        chk("rr_first_rdy0", {31'd0, req0_ready}, 1);
        chk("rr_first_rdy1", {31'd0, req1_ready}, 0);
        chk("rr_alu_op", {28'd0, alu_op}, {28'd0, ALU_SLT});
        tick();
        req0_valid = 0;
        @(negedge CLK);
        chk("slt_resp0_valid", {31'd0, resp0_valid}, 1);
        tick();
        @(negedge CLK);
        chk("sub_rdy1", {31'd0, req1_ready}, 1);
        tick();
        req1_valid = 0;
        @(negedge CLK);
        chk("sub_resp1_valid", {31'd0, resp1_valid}, 1);
        tick();
        @(negedge CLK);
        chk("sub_resp1_clear", {31'd0, resp1_valid}, 0);

        repeat (2) @(negedge CLK);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
